// File: rtl/vga_bus_pkg.sv
// Shared constants for the VGA bus bridge: register offsets, CTRL bit positions, FSM states.
// No logic; imported by the bridge top.
package vga_bus_pkg;

  localparam logic [7:0] OFF_Y      = 8'd0;
  localparam logic [7:0] OFF_X      = 8'd1;
  localparam logic [7:0] OFF_PIXEL  = 8'd2;
  localparam logic [7:0] OFF_CTRL   = 8'd3;
  localparam logic [7:0] OFF_FILL   = 8'd4;
  localparam logic [7:0] OFF_COL_LO = 8'd5;
  localparam logic [7:0] OFF_COL_HI = 8'd6;
  localparam logic [7:0] N_REGS     = 8'd7;

  localparam int CTRL_AUTO_INC = 0;
  localparam int CTRL_BUSY     = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/vga_raster_counter.sv
// Raster-order X/Y counter with clear, per-axis load and wrap at the visible frame edge.
// Updates one cycle after en/load/clr; last_o is combinational from the current position.
module vga_raster_counter #(
  parameter int X_BITS   = 8,
  parameter int Y_BITS   = 7,
  parameter int H_PIXELS = 160,
  parameter int V_PIXELS = 120
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic              ld_x_vld_i,
  input  logic [X_BITS-1:0] ld_x_dat_i,
  input  logic              ld_y_vld_i,
  input  logic [Y_BITS-1:0] ld_y_dat_i,
  output logic [X_BITS-1:0] x_o,
  output logic [Y_BITS-1:0] y_o,
  output logic              last_o
);

  localparam logic [X_BITS-1:0] X_LAST = X_BITS'(H_PIXELS - 1);
  localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(V_PIXELS - 1);

  logic [X_BITS-1:0] x_q, x_d;
  logic [Y_BITS-1:0] y_q, y_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr_i) begin
      x_d = '0;
      y_d = '0;
    end else begin
      if (en_i) begin
        if (x_q == X_LAST) begin
          x_d = '0;
          y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
        end else begin
          x_d = x_q + 1'b1;
        end
      end
      // Bus loads take precedence; the bus never loads and steps in the same cycle.
      if (ld_x_vld_i) x_d = ld_x_dat_i;
      if (ld_y_vld_i) y_d = ld_y_dat_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign last_o = (x_q == X_LAST) && (y_q == Y_LAST);

endmodule

// File: rtl/vga_bus_bridge.sv
// Bus-side controller for frame-buffer port A: register window, cursor, readback, colours, fill engine.
// Pixel writes reach the frame buffer one cycle after the bus write; reads are registered; no backpressure.
module vga_bus_bridge
  import vga_bus_pkg::*;
#(
  parameter logic [7:0]  BASE_ADDR       = 8'hB0,
  parameter int          X_BITS          = 8,
  parameter int          Y_BITS          = 7,
  parameter int          H_PIXELS        = 160,
  parameter int          V_PIXELS        = 120,
  parameter int          PIXEL_BITS      = 1,
  parameter logic [15:0] DEFAULT_COLOURS = 16'h3333
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [7:0]               BUS_ADDR,
  input  logic [7:0]               BUS_DATA_IN,
  input  logic                     BUS_WE,
  output logic [7:0]               BUS_DATA_OUT,
  output logic [Y_BITS+X_BITS-1:0] FB_ADDR,
  output logic [PIXEL_BITS-1:0]    FB_DATA,
  output logic                     FB_WE,
  input  logic [PIXEL_BITS-1:0]    FB_RDATA,
  output logic [15:0]              CONFIG_COLOURS,
  output logic                     BUSY,
  output logic                     IRQ
);

  localparam logic [X_BITS-1:0] X_LAST = X_BITS'(H_PIXELS - 1);
  localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(V_PIXELS - 1);

  state_t                     state_q, state_d;
  logic                       auto_inc_q, auto_inc_d;
  logic [15:0]                colours_q, colours_d;
  logic [PIXEL_BITS-1:0]      fill_col_q, fill_col_d;
  logic [Y_BITS+X_BITS-1:0]   fb_addr_q, fb_addr_d;
  logic [PIXEL_BITS-1:0]      fb_data_q, fb_data_d;
  logic                       fb_we_q, fb_we_d;
  logic [7:0]                 rdata_q, rdata_d;

  logic [7:0]        off;
  logic              hit, wr, busy, idle;
  logic              wr_y, wr_x, wr_pix, wr_ctrl, wr_fill, wr_lo, wr_hi;
  logic              cur_in_range, pix_ok;
  logic [X_BITS-1:0] cur_x, walk_x;
  logic [Y_BITS-1:0] cur_y, walk_y;
  logic              cur_last, walk_last;
  logic              unused_cur_last;

  // Offset wraps below BASE_ADDR, so a single compare decodes the window.
  assign off  = BUS_ADDR - BASE_ADDR;
  assign hit  = off < N_REGS;
  assign wr   = BUS_WE && hit;
  assign busy = (state_q == FILL);
  assign idle = (state_q == IDLE);

  assign wr_y    = wr && (off == OFF_Y) && !busy;
  assign wr_x    = wr && (off == OFF_X) && !busy;
  assign wr_pix  = wr && (off == OFF_PIXEL) && idle;
  assign wr_ctrl = wr && (off == OFF_CTRL);
  assign wr_fill = wr && (off == OFF_FILL) && idle;
  assign wr_lo   = wr && (off == OFF_COL_LO);
  assign wr_hi   = wr && (off == OFF_COL_HI);

  assign cur_in_range = (cur_x <= X_LAST) && (cur_y <= Y_LAST);
  assign pix_ok       = wr_pix && cur_in_range;

  vga_raster_counter #(
    .X_BITS(X_BITS), .Y_BITS(Y_BITS), .H_PIXELS(H_PIXELS), .V_PIXELS(V_PIXELS)
  ) u_cursor (
    .clk_i      (CLK),
    .rst_i      (RESET),
    .clr_i      (1'b0),
    .en_i       (pix_ok && auto_inc_q),
    .ld_x_vld_i (wr_x),
    .ld_x_dat_i (X_BITS'(BUS_DATA_IN)),
    .ld_y_vld_i (wr_y),
    .ld_y_dat_i (Y_BITS'(BUS_DATA_IN)),
    .x_o        (cur_x),
    .y_o        (cur_y),
    .last_o     (cur_last)
  );

  assign unused_cur_last = cur_last;

  vga_raster_counter #(
    .X_BITS(X_BITS), .Y_BITS(Y_BITS), .H_PIXELS(H_PIXELS), .V_PIXELS(V_PIXELS)
  ) u_walker (
    .clk_i      (CLK),
    .rst_i      (RESET),
    .clr_i      (wr_fill),
    .en_i       (busy),
    .ld_x_vld_i (1'b0),
    .ld_x_dat_i ('0),
    .ld_y_vld_i (1'b0),
    .ld_y_dat_i ('0),
    .x_o        (walk_x),
    .y_o        (walk_y),
    .last_o     (walk_last)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (wr_fill) state_d = FILL;
      FILL:    if (walk_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    auto_inc_d = auto_inc_q;
    colours_d  = colours_q;
    fill_col_d = fill_col_q;
    if (wr_ctrl) auto_inc_d = BUS_DATA_IN[CTRL_AUTO_INC];
    if (wr_lo)   colours_d[7:0] = BUS_DATA_IN;
    if (wr_hi)   colours_d[15:8] = BUS_DATA_IN;
    if (wr_fill) fill_col_d = BUS_DATA_IN[PIXEL_BITS-1:0];
  end

  // The port address tracks the cursor so PIXEL reads see RAM data two cycles later.
  always_comb begin
    fb_addr_d = {cur_y, cur_x};
    fb_data_d = fb_data_q;
    fb_we_d   = 1'b0;
    if (pix_ok) begin
      fb_we_d   = 1'b1;
      fb_data_d = BUS_DATA_IN[PIXEL_BITS-1:0];
    end
  end

  always_comb begin
    rdata_d = '0;
    case (off)
      OFF_Y:      rdata_d = 8'(cur_y);
      OFF_X:      rdata_d = 8'(cur_x);
      OFF_PIXEL:  rdata_d = 8'(FB_RDATA);
      OFF_CTRL: begin
        rdata_d[CTRL_AUTO_INC] = auto_inc_q;
        rdata_d[CTRL_BUSY]     = busy;
      end
      OFF_COL_LO: rdata_d = colours_q[7:0];
      OFF_COL_HI: rdata_d = colours_q[15:8];
      default:    rdata_d = '0;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      auto_inc_q <= 1'b0;
      colours_q  <= DEFAULT_COLOURS;
      fill_col_q <= '0;
      fb_addr_q  <= '0;
      fb_data_q  <= '0;
      fb_we_q    <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      auto_inc_q <= auto_inc_d;
      colours_q  <= colours_d;
      fill_col_q <= fill_col_d;
      fb_addr_q  <= fb_addr_d;
      fb_data_q  <= fb_data_d;
      fb_we_q    <= fb_we_d;
      rdata_q    <= rdata_d;
    end
  end

  // During a fill the walker drives the port directly so writes start the cycle BUSY rises.
  assign FB_ADDR        = busy ? {walk_y, walk_x} : fb_addr_q;
  assign FB_DATA        = busy ? fill_col_q : fb_data_q;
  assign FB_WE          = busy || fb_we_q;
  assign BUS_DATA_OUT   = rdata_q;
  assign CONFIG_COLOURS = colours_q;
  assign BUSY           = busy;
  assign IRQ            = (state_q == DONE);

endmodule

// File: tb/tb_vga_bus_bridge.sv
// Randomised bench for vga_bus_bridge against a coordinate-level model of cursor, registers and frame buffer.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_vga_bus_bridge;

  localparam int H = 160;
  localparam int V = 120;
  localparam int NPIX = H * V;
  localparam logic [7:0] B = 8'hB0;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [7:0]  BUS_ADDR;
  logic [7:0]  BUS_DATA_IN;
  logic        BUS_WE;
  logic [7:0]  BUS_DATA_OUT;
  logic [14:0] FB_ADDR;
  logic [0:0]  FB_DATA;
  logic        FB_WE;
  logic [0:0]  FB_RDATA;
  logic [15:0] CONFIG_COLOURS;
  logic        BUSY;
  logic        IRQ;

  vga_bus_bridge dut (
    .CLK(CLK), .RESET(RESET), .BUS_ADDR(BUS_ADDR), .BUS_DATA_IN(BUS_DATA_IN),
    .BUS_WE(BUS_WE), .BUS_DATA_OUT(BUS_DATA_OUT), .FB_ADDR(FB_ADDR),
    .FB_DATA(FB_DATA), .FB_WE(FB_WE), .FB_RDATA(FB_RDATA),
    .CONFIG_COLOURS(CONFIG_COLOURS), .BUSY(BUSY), .IRQ(IRQ)
  );

  always #5 CLK = ~CLK;

  // Synchronous frame-buffer RAM, read-before-write.
  logic mem [0:32767];
  always @(posedge CLK) begin
    if (FB_WE) mem[FB_ADDR] <= FB_DATA[0];
    FB_RDATA <= mem[FB_ADDR];
  end

  // Reference model
  int          m_x, m_y;
  bit          m_auto;
  logic [15:0] m_col;
  bit          ref_fb [V][H];

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [7:0] exp_reg(input int off);
    case (off)
      0:       return 8'(m_y);
      1:       return 8'(m_x);
      3:       return {7'b0, m_auto};
      5:       return m_col[7:0];
      6:       return m_col[15:8];
      default: return 8'h00;
    endcase
  endfunction

  task automatic idle_cycle();
    @(negedge CLK);
    BUS_WE = 1'b0;
    BUS_ADDR = 8'h00;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge CLK);
    BUS_ADDR = a;
    BUS_DATA_IN = d;
    BUS_WE = 1'b1;
    @(negedge CLK);
    BUS_WE = 1'b0;
    BUS_ADDR = 8'h00;
    // Model: writes to Y/X/CTRL/colours while idle
    if (a == B + 8'd0) m_y = d % 128;
    if (a == B + 8'd1) m_x = d;
    if (a == B + 8'd3) m_auto = d[0];
    if (a == B + 8'd5) m_col[7:0] = d;
    if (a == B + 8'd6) m_col[15:8] = d;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
    @(negedge CLK);
    BUS_ADDR = a;
    BUS_WE = 1'b0;
    @(negedge CLK);
    d = BUS_DATA_OUT;
    BUS_ADDR = 8'h00;
  endtask

  task automatic pix_write(input logic [7:0] d);
    bit inr;
    inr = (m_x < H) && (m_y < V);
    @(negedge CLK);
    BUS_ADDR = B + 8'd2;
    BUS_DATA_IN = d;
    BUS_WE = 1'b1;
    @(negedge CLK);
    BUS_WE = 1'b0;
    BUS_ADDR = 8'h00;
    chk("pix_fb_we", FB_WE, inr);
    if (inr) begin
      chk("pix_fb_addr", FB_ADDR, (m_y << 8) + m_x);
      chk("pix_fb_data", FB_DATA, d[0]);
    end
    @(negedge CLK);
    chk("pix_fb_we_once", FB_WE, 0);
    if (inr) begin
      ref_fb[m_y][m_x] = d[0];
      if (m_auto) begin
        m_x++;
        if (m_x == H) begin
          m_x = 0;
          m_y++;
          if (m_y == V) m_y = 0;
        end
      end
    end
  endtask

  task automatic pix_read();
    logic [7:0] d;
    idle_cycle();
    idle_cycle();
    bus_read(B + 8'd2, d);
    if ((m_x < H) && (m_y < V)) chk("pix_read", d, {7'b0, ref_fb[m_y][m_x]});
  endtask

  // Full fill with bus traffic injected mid-fill, at the last fill cycle and during DONE.
  task automatic run_fill(input logic [7:0] col);
    int err_addr, err_data, err_we, err_busy, n_we, n_irq;
    logic [7:0] st;
    err_addr = 0; err_data = 0; err_we = 0; err_busy = 0; n_we = 0; n_irq = 0;
    st = 8'h00;
    @(negedge CLK);
    BUS_ADDR = B + 8'd4;
    BUS_DATA_IN = col;
    BUS_WE = 1'b1;
    for (int c = 0; c < NPIX + 6; c++) begin
      @(negedge CLK);
      if (c < NPIX) begin
        if (FB_ADDR !== 15'(((c / H) << 8) + (c % H))) err_addr++;
        if (FB_DATA !== col[0]) err_data++;
      end
      if (FB_WE !== (c < NPIX)) err_we++;
      if (FB_WE === 1'b1) n_we++;
      if (BUSY !== (c < NPIX)) err_busy++;
      if (IRQ === 1'b1) begin
        n_irq++;
        chk("fill_irq_cycle", c, NPIX);
      end
      if (c == 401) st = BUS_DATA_OUT;
      BUS_WE = 1'b0;
      BUS_ADDR = 8'h00;
      BUS_DATA_IN = 8'h01;
      case (c)
        100:     begin BUS_ADDR = B + 8'd2; BUS_WE = 1'b1; end
        200:     begin BUS_ADDR = B + 8'd0; BUS_DATA_IN = 8'd3; BUS_WE = 1'b1; end
        300:     begin BUS_ADDR = B + 8'd1; BUS_DATA_IN = 8'd7; BUS_WE = 1'b1; end
        400:     BUS_ADDR = B + 8'd3;
        NPIX-1:  begin BUS_ADDR = B + 8'd2; BUS_WE = 1'b1; end
        NPIX:    begin BUS_ADDR = B + 8'd4; BUS_WE = 1'b1; end
        default: ;
      endcase
    end
    chk("fill_addr_errs", err_addr, 0);
    chk("fill_data_errs", err_data, 0);
    chk("fill_we_errs", err_we, 0);
    chk("fill_we_count", n_we, NPIX);
    chk("fill_busy_errs", err_busy, 0);
    chk("fill_irq_count", n_irq, 1);
    chk("fill_status", st, {7'b1000000, m_auto});
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) ref_fb[y][x] = col[0];
  endtask

  logic [7:0] rd;
  int op, r, n_irq_rst;

  initial begin
    RESET = 1'b1;
    BUS_ADDR = 8'h00;
    BUS_DATA_IN = 8'h00;
    BUS_WE = 1'b0;
    for (int i = 0; i < 32768; i++) mem[i] = 1'b0;
    m_x = 0; m_y = 0; m_auto = 1'b0; m_col = 16'h3333;
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) ref_fb[y][x] = 1'b0;

    repeat (3) @(negedge CLK);
    chk("rst_fb_we", FB_WE, 0);
    chk("rst_busy", BUSY, 0);
    RESET = 1'b0;
    @(negedge CLK);
    chk("rst_rdata", BUS_DATA_OUT, 0);
    chk("rst_colours", CONFIG_COLOURS, 16'h3333);
    chk("rst_irq", IRQ, 0);
    chk("rst_fb_addr", FB_ADDR, 0);
    bus_read(B + 8'd3, rd);
    chk("rst_ctrl", rd, 8'h00);

    // Single pixel, no auto-increment
    bus_write(B + 8'd0, 8'd5);
    bus_write(B + 8'd1, 8'd10);
    pix_write(8'd1);
    bus_read(B + 8'd1, rd);
    chk("x_no_inc", rd, 8'd10);
    pix_read();

    // Auto-increment with full-frame wrap
    bus_write(B + 8'd3, 8'd1);
    bus_write(B + 8'd0, 8'd119);
    bus_write(B + 8'd1, 8'd159);
    pix_write(8'd1);
    pix_write(8'd1);
    bus_read(B + 8'd1, rd);
    chk("wrap_x", rd, 8'd1);
    bus_read(B + 8'd0, rd);
    chk("wrap_y", rd, 8'd0);
    bus_write(B + 8'd3, 8'd0);

    run_fill(8'd1);
    bus_read(B + 8'd0, rd);
    chk("fill_keeps_y", rd, exp_reg(0));
    bus_read(B + 8'd1, rd);
    chk("fill_keeps_x", rd, exp_reg(1));
    pix_read();

    // Out-of-range cursor and colour registers
    bus_write(B + 8'd1, 8'd200);
    pix_write(8'd1);
    bus_read(B + 8'd1, rd);
    chk("x_oor_kept", rd, 8'd200);
    bus_write(B + 8'd5, 8'hAA);
    bus_write(B + 8'd6, 8'h55);
    chk("colours_out", CONFIG_COLOURS, 16'h55AA);
    bus_read(B + 8'd6, rd);
    chk("col_hi_read", rd, 8'h55);

    for (int i = 0; i < 400; i++) begin
      op = $urandom_range(0, 9);
      case (op)
        0: bus_write(B + 8'd0, ($urandom_range(0, 3) != 0) ? 8'($urandom_range(0, V - 1)) : 8'($urandom_range(0, 255)));
        1: bus_write(B + 8'd1, ($urandom_range(0, 3) != 0) ? 8'($urandom_range(0, H - 1)) : 8'($urandom_range(0, 255)));
        2, 3: pix_write(8'($urandom));
        4: bus_write(B + 8'd3, 8'($urandom));
        5: bus_write(B + 8'($urandom_range(5, 6)), 8'($urandom));
        6: begin
          r = $urandom_range(0, 8);
          if (r == 2) pix_read();
          else if (r == 8) begin
            bus_read(8'($urandom_range(0, 8'hAF)), rd);
            chk("rand_read_outside", rd, 8'h00);
          end else begin
            bus_read(B + 8'(r), rd);
            chk("rand_read", rd, exp_reg(r));
          end
        end
        7: pix_read();
        8: begin
          bus_write(($urandom_range(0, 1) != 0) ? B + 8'd7 : 8'($urandom_range(0, 8'hAF)), 8'($urandom));
          chk("rand_colours", CONFIG_COLOURS, m_col);
        end
        default: idle_cycle();
      endcase
    end

    // Reset in the middle of a fill
    @(negedge CLK);
    BUS_ADDR = B + 8'd4;
    BUS_DATA_IN = 8'd1;
    BUS_WE = 1'b1;
    @(negedge CLK);
    BUS_WE = 1'b0;
    BUS_ADDR = 8'h00;
    repeat (50) @(negedge CLK);
    chk("midfill_busy", BUSY, 1);
    RESET = 1'b1;
    #1;
    chk("rst_mid_fb_we", FB_WE, 0);
    chk("rst_mid_busy", BUSY, 0);
    chk("rst_mid_irq", IRQ, 0);
    chk("rst_mid_colours", CONFIG_COLOURS, 16'h3333);
    chk("rst_mid_fb_addr", FB_ADDR, 0);
    @(negedge CLK);
    RESET = 1'b0;
    m_x = 0; m_y = 0; m_auto = 1'b0; m_col = 16'h3333;
    n_irq_rst = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (IRQ === 1'b1) n_irq_rst++;
    end
    chk("rst_mid_no_irq", n_irq_rst, 0);

    run_fill(8'd0);
    for (int i = 0; i < 6; i++) begin
      bus_write(B + 8'd0, 8'($urandom_range(0, V - 1)));
      bus_write(B + 8'd1, 8'($urandom_range(0, H - 1)));
      pix_read();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
